// File: rtl/mul_sequencer.sv
// Shift-add multiplier controller sharing the execute-stage add/sub unit; WORD RUN cycles per product.
// start is taken only in IDLE (ready=1); done pulses one cycle after the last RUN update.
module mul_sequencer #(
  parameter int WORD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_signed,
  input  logic [WORD-1:0]   mcand,
  input  logic [WORD-1:0]   mplier,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [2*WORD-1:0] product,
  output logic [WORD-1:0]   au_a,
  output logic [WORD-1:0]   au_b,
  output logic [1:0]        au_op,
  output logic              au_cin,
  input  logic [WORD-1:0]   au_res,
  input  logic              au_cout,
  input  logic              au_ovf
);

  localparam int CW = $clog2(WORD);
  localparam logic [CW-1:0] LAST = CW'(WORD - 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WORD-1:0] p_hi_q, p_hi_d;
  logic [WORD-1:0] p_lo_q, p_lo_d;
  logic [WORD-1:0] mcand_q, mcand_d;
  logic            signed_q, signed_d;
  logic            ext;
  logic            last_iter;

  assign last_iter = (count_q == LAST);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    mcand_d  = mcand_q;
    signed_d = signed_q;
    au_a     = '0;
    au_b     = '0;
    au_op    = OP_ADD;
    au_cin   = 1'b0;
    ext      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = mcand;
          signed_d = is_signed;
          p_hi_d   = '0;
          p_lo_d   = mplier;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        au_a  = p_hi_q;
        au_b  = p_lo_q[0] ? mcand_q : '0;
        // Multiplier MSB carries negative weight in two's complement.
        au_op = (signed_q && last_iter) ? OP_SUB : OP_ADD;
        // True sign of the signed sum/difference is res MSB corrected by overflow.
        ext   = signed_q ? (au_res[WORD-1] ^ au_ovf) : au_cout;
        {p_hi_d, p_lo_d} = {ext, au_res, p_lo_q[WORD-1:1]};
        count_d = count_q + 1'b1;
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      mcand_q  <= '0;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      mcand_q  <= mcand_d;
      signed_q <= signed_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = {p_hi_q, p_lo_q};

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed and randomized checks of mul_sequencer against a behavioural add/sub unit.
module tb_mul_sequencer;

  localparam int WORD = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              is_signed;
  logic [WORD-1:0]   mcand;
  logic [WORD-1:0]   mplier;
  logic              ready;
  logic              busy;
  logic              done;
  logic [2*WORD-1:0] product;
  logic [WORD-1:0]   au_a;
  logic [WORD-1:0]   au_b;
  logic [1:0]        au_op;
  logic              au_cin;
  logic [WORD-1:0]   au_res;
  logic              au_cout;
  logic              au_ovf;

  int checks = 0;
  int errors = 0;
  int cin_bad = 0;

  mul_sequencer #(.WORD(WORD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .mcand(mcand), .mplier(mplier), .ready(ready), .busy(busy), .done(done),
    .product(product), .au_a(au_a), .au_b(au_b), .au_op(au_op), .au_cin(au_cin),
    .au_res(au_res), .au_cout(au_cout), .au_ovf(au_ovf)
  );

  // Arithmetic unit: 00 = a+b+cin, 10 = a-b (carry out means no borrow).
  logic [WORD:0]   au_sum;
  logic [WORD-1:0] au_bx;
  always_comb begin
    au_bx = (au_op == 2'b10) ? ~au_b : au_b;
    au_sum = {1'b0, au_a} + {1'b0, au_bx} + ((au_op == 2'b10) ? (WORD+1)'(1) : (WORD+1)'(au_cin));
    au_res = au_sum[WORD-1:0];
    au_cout = au_sum[WORD];
    au_ovf = (au_a[WORD-1] == au_bx[WORD-1]) && (au_res[WORD-1] != au_a[WORD-1]);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (au_cin !== 1'b0) cin_bad++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic sgn, input logic [WORD-1:0] a, input logic [WORD-1:0] b,
                        output logic [2*WORD-1:0] prod, output int edges, output int busy_n,
                        output int bnz, output logic [1:0] last_op);
    int n;
    n = 0;
    while (!ready && n < 50) begin tick(); n++; end
    if (!ready) check("ready_timeout", {63'd0, ready}, 64'd1);
    is_signed = sgn; mcand = a; mplier = b; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0; busy_n = 0; bnz = 0; last_op = 2'b00;
    while (!done && edges < 50) begin
      if (busy) begin
        busy_n++;
        if (au_b != '0) bnz++;
        last_op = au_op;
      end
      tick();
      edges++;
    end
    if (!done) check("done_timeout", {63'd0, done}, 64'd1);
    prod = product;
  endtask

  initial begin
    logic [2*WORD-1:0] prod, held, expp;
    logic [1:0]        lop;
    logic [WORD-1:0]   ra, rb;
    logic              rs;
    logic signed [2*WORD-1:0] sa, sb;
    int                edges, busy_n, bnz, gap;

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; mcand = '0; mplier = '0;
    repeat (2) tick();
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_product", {32'd0, product}, 64'd0);
    check("idle_au", {30'd0, au_op, au_a, au_b}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Unsigned full scale, with latency and pulse width.
    run_op(1'b0, 16'hFFFF, 16'hFFFF, prod, edges, busy_n, bnz, lop);
    check("u_ffff_prod", {32'd0, prod}, 64'hFFFE0001);
    check("u_ffff_done_edges", edges, 64'd16);
    check("u_ffff_busy_cycles", busy_n, 64'd16);
    tick();
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("ready_after_done", {63'd0, ready}, 64'd1);

    run_op(1'b1, 16'hFFFF, 16'hFFFF, prod, edges, busy_n, bnz, lop);
    check("s_ffff_prod", {32'd0, prod}, 64'h00000001);
    run_op(1'b1, 16'h8000, 16'h8000, prod, edges, busy_n, bnz, lop);
    check("s_8000sq_prod", {32'd0, prod}, 64'h40000000);
    check("s_8000sq_last_op", {62'd0, lop}, 64'd2);
    run_op(1'b1, 16'h8000, 16'h0001, prod, edges, busy_n, bnz, lop);
    check("s_8000x1_prod", {32'd0, prod}, 64'hFFFF8000);
    run_op(1'b0, 16'h0000, 16'hBEEF, prod, edges, busy_n, bnz, lop);
    check("u_zero_prod", {32'd0, prod}, 64'd0);
    check("u_zero_au_b", bnz, 64'd0);
    run_op(1'b1, 16'h0007, 16'hFFFD, prod, edges, busy_n, bnz, lop);
    check("s_7xm3_prod", {32'd0, prod}, 64'hFFFFFFEB);
    run_op(1'b0, 16'h1234, 16'h5678, prod, edges, busy_n, bnz, lop);
    check("u_1234x5678_prod", {32'd0, prod}, 64'h06260060);
    check("u_last_op_add", {62'd0, lop}, 64'd0);

    // start held high: only IDLE-state requests are taken.
    tick();
    is_signed = 1'b0; mcand = 16'd3; mplier = 16'd5; start = 1'b1;
    tick();
    is_signed = 1'b1; mcand = 16'hFFFF; mplier = 16'hFFFF;
    edges = 0;
    while (!done && edges < 50) begin tick(); edges++; end
    check("hs_first_prod", {32'd0, product}, 64'h0000000F);
    gap = 0;
    tick(); gap++;
    check("hs_ready_idle", {63'd0, ready}, 64'd1);
    tick(); gap++;
    start = 1'b0;
    check("hs_second_accepted", {63'd0, busy}, 64'd1);
    while (!done && gap < 60) begin tick(); gap++; end
    check("hs_done_spacing", gap, 64'd18);
    check("hs_second_prod", {32'd0, product}, 64'h00000001);
    held = product;
    mcand = 16'h1111; mplier = 16'h2222;
    repeat (5) tick();
    check("hs_product_hold", {32'd0, product}, {32'd0, held});

    // Reset in the middle of RUN.
    is_signed = 1'b0; mcand = 16'hABCD; mplier = 16'h1357; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("mid_busy_before_rst", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_ready", {63'd0, ready}, 64'd1);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_product", {32'd0, product}, 64'd0);
    run_op(1'b0, 16'd3, 16'd5, prod, edges, busy_n, bnz, lop);
    check("after_rst_3x5", {32'd0, prod}, 64'h0000000F);

    // Random operands against a reference multiply.
    for (int i = 0; i < 1500; i++) begin
      ra = WORD'($urandom);
      rb = WORD'($urandom);
      rs = 1'($urandom);
      if (rs) begin
        sa = $signed(ra);
        sb = $signed(rb);
        expp = 32'(sa * sb);
      end else begin
        expp = {16'd0, ra} * {16'd0, rb};
      end
      run_op(rs, ra, rb, prod, edges, busy_n, bnz, lop);
      check($sformatf("rand_%0d_%0d_%h_%h", i, rs, ra, rb), {32'd0, prod}, {32'd0, expp});
    end

    check("au_cin_zero", cin_bad, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
